// File: rtl/griffin_arbiter.sv
// griffin_arbiter: round-robin sharing of one griffin permutation core among NUM_REQ requesters
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   req_valid/ready     per-requester request handshake (ready is one-hot, IDLE only)
//   req_state           NUM_REQ packed jobs; requester i occupies bits [i*W +: W]
//   resp_valid/ready    response handshake; resp_id, resp_err, resp_state qualify it
//   core_enable         one-cycle launch pulse to the core
//   core_reset          core reset: system reset or watchdog expiry
//   core_in             registered job, held from launch until the response is taken
//   core_done, core_out completion pulse and result from the core
//   busy                high whenever a job is in flight or awaiting pickup
//   jobs_done           count of delivered responses (ok and error), wraps
// Within a job, word w of the batch sits at bits [w*N_BITS +: N_BITS].
module griffin_arbiter #(
    parameter int N_BITS = 254,
    parameter int STATE_SIZE = 3,
    parameter int BATCH = 13,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int W = N_BITS * STATE_SIZE * BATCH,
    localparam int IW = $clog2(NUM_REQ),
    localparam int TW = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_state,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IW-1:0]        resp_id,
    output logic                 resp_err,
    output logic [W-1:0]         resp_state,
    output logic                 core_enable,
    output logic                 core_reset,
    output logic [W-1:0]         core_in,
    input  logic                 core_done,
    input  logic [W-1:0]         core_out,
    output logic                 busy,
    output logic [31:0]          jobs_done
);
    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;

    state_t        r_state;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] r_grant_id;
    logic [TW-1:0] r_timer;
    logic [W-1:0]  r_core_in;
    logic [W-1:0]  r_resp_state;
    logic          r_resp_err;
    logic [31:0]   r_jobs_done;

    logic          w_found;
    logic [IW-1:0] w_win;
    logic [IW-1:0] w_idx;
    logic          w_wd;

    // Modulo-NUM_REQ reduction of a pointer plus a small offset (< NUM_REQ).
    function automatic logic [IW-1:0] wrap(input logic [IW:0] v);
        return (v >= (IW+1)'(NUM_REQ)) ? IW'(v - (IW+1)'(NUM_REQ)) : v[IW-1:0];
    endfunction

    // Scan from the far end down so the nearest valid requester after rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = wrap({1'b0, r_rr_ptr} + (IW+1)'(k));
            if (req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // A core_done arriving on the expiry cycle takes precedence over the watchdog.
    assign w_wd = (r_state == BUSY) && !core_done && (r_timer == TW'(TIMEOUT_CYCLES - 1));

    assign req_ready   = (r_state == IDLE && w_found && !reset) ? (NUM_REQ'(1) << w_win) : '0;
    assign core_enable = (r_state == LAUNCH);
    assign core_reset  = reset | w_wd;
    assign resp_valid  = (r_state == RESP);
    assign busy        = (r_state != IDLE);
    assign resp_id     = r_grant_id;
    assign resp_err    = r_resp_err;
    assign resp_state  = r_resp_state;
    assign core_in     = r_core_in;
    assign jobs_done   = r_jobs_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_timer      <= '0;
            r_core_in    <= '0;
            r_resp_state <= '0;
            r_resp_err   <= 1'b0;
            r_jobs_done  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_core_in  <= req_state[w_win*W +: W];
                    r_grant_id <= w_win;
                    r_state    <= LAUNCH;
                end
                LAUNCH: begin
                    r_timer <= '0;
                    r_state <= BUSY;
                end
                BUSY: begin
                    r_timer <= r_timer + TW'(1);
                    if (core_done) begin
                        r_resp_state <= core_out;
                        r_resp_err   <= 1'b0;
                        r_state      <= RESP;
                    end else if (w_wd) begin
                        r_resp_state <= '0;
                        r_resp_err   <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                RESP: if (resp_ready) begin
                    r_rr_ptr    <= wrap({1'b0, r_grant_id} + (IW+1)'(1));
                    r_jobs_done <= r_jobs_done + 32'd1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_griffin_arbiter.sv
// tb_griffin_arbiter: table-driven and scoreboarded check of griffin_arbiter with a stub core
module tb_griffin_arbiter;
    localparam int N = 254, NR = 4, TO = 64, NW = 3 * 13, W = NW * N, LAT = 40;

    logic clk = 1'b0, reset = 1'b1, resp_ready = 1'b1, hang = 1'b0;
    logic [NR-1:0] req_valid = '0, req_ready;
    logic [NR*W-1:0] req_state = '0;
    logic resp_valid, resp_err, core_enable, core_reset, core_done, busy;
    logic [1:0] resp_id;
    logic [W-1:0] resp_state, core_in, core_out;
    logic [31:0] jobs_done;

    griffin_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_state(req_state), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_err(resp_err), .resp_state(resp_state),
        .core_enable(core_enable), .core_reset(core_reset), .core_in(core_in),
        .core_done(core_done), .core_out(core_out), .busy(busy), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    logic run;
    int cnt;
    always_ff @(posedge clk) begin
        if (core_reset) begin
            run <= 1'b0;
            cnt <= 0;
        end else if (core_enable) begin
            run <= 1'b1;
            cnt <= 0;
        end else if (run) begin
            cnt <= cnt + 1;
            if (core_done) run <= 1'b0;
        end
    end
    assign core_done = run && !hang && (cnt == LAT - 1);
    always_comb begin
        core_out = '0;
        for (int w = 0; w < NW; w++) core_out[w*N +: N] = core_in[w*N +: N] + N'(1);
    end

    typedef struct {logic [1:0] id; logic err; logic [N-1:0] word;} exp_t;
    typedef struct {logic rst; logic [3:0] mask; logic [N-1:0] base; int n; logic [3:0][1:0] ord;} vec_t;

    exp_t sb[$];
    vec_t tv[8];
    int total = 0, bad = 0, cyc = 0, en_cyc = 0, rv_cyc = 0, cr_cyc = 0, cr_cnt = 0, exp_jobs = 0;
    logic [NR-1:0] prev_acc = '0;
    logic rv_prev = 1'b0;

    function automatic logic [W-1:0] fill(input logic [N-1:0] v);
        logic [W-1:0] r;
        for (int w = 0; w < NW; w++) r[w*N +: N] = v;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic err, input logic [N-1:0] word);
        sb.push_back(exp_t'{id, err, word});
    endtask

    task automatic apply(input logic [NR-1:0] m, input logic [N-1:0] base);
        for (int i = 0; i < NR; i++) if (m[i]) req_state[i*W +: W] = fill(base + N'(i));
        req_valid = req_valid | m;
    endtask

    task automatic step();
        logic [NR-1:0] acc;
        exp_t e;
        @(negedge clk);
        chk("core_enable", core_enable, |prev_acc);
        acc = reset ? '0 : (req_valid & req_ready);
        if (core_enable) en_cyc = cyc;
        if (resp_valid && !rv_prev) rv_cyc = cyc;
        if (core_reset && !reset) begin
            cr_cyc = cyc;
            cr_cnt++;
        end
        rv_prev = resp_valid;
        if (!reset && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp id=%0d", resp_id);
            end else begin
                e = sb.pop_front();
                exp_jobs++;
                chk("resp_id", resp_id, e.id);
                chk("resp_err", resp_err, e.err);
                total++;
                if (resp_state !== fill(e.word)) begin
                    bad++;
                    $display("FAIL resp_state word0 got=%0h want=%0h", resp_state[N-1:0], e.word);
                end
            end
        end
        prev_acc = acc;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout left=%0d", sb.size());
            sb.delete();
        end
        chk("jobs_done", jobs_done, exp_jobs);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (2) step();
        reset = 1'b0;
        exp_jobs = 0;
    endtask

    initial begin
        tv[0] = '{1'b1, 4'b0101, N'(10), 2, {2'd0, 2'd0, 2'd2, 2'd0}};
        tv[1] = '{1'b0, 4'b1111, N'(20), 4, {2'd2, 2'd1, 2'd0, 2'd3}};
        tv[2] = '{1'b1, 4'b1111, N'(30), 4, {2'd3, 2'd2, 2'd1, 2'd0}};
        tv[3] = '{1'b0, 4'b1111, N'(40), 4, {2'd3, 2'd2, 2'd1, 2'd0}};
        tv[4] = '{1'b0, 4'b0110, N'(50), 2, {2'd0, 2'd0, 2'd2, 2'd1}};
        tv[5] = '{1'b0, 4'b1001, N'(60), 2, {2'd0, 2'd0, 2'd0, 2'd3}};
        tv[6] = '{1'b0, 4'b0001, N'(70), 1, {2'd0, 2'd0, 2'd0, 2'd0}};
        tv[7] = '{1'b0, 4'b1100, N'(80), 2, {2'd0, 2'd0, 2'd3, 2'd2}};

        req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_jobs_done", jobs_done, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_core_enable", core_enable, 0);
        chk("rst_core_in", core_in[N-1:0], 0);
        chk("rst_resp_state", resp_state[N-1:0], 0);
        req_valid = '0;
        reset = 1'b0;

        apply(4'b0010, N'(4));
        push(2'd1, 1'b0, N'(6));
        #1;
        chk("single_ready", req_ready, 4'b0010);
        drain(200);
        chk("single_latency", N'(rv_cyc - en_cyc), N'(LAT + 1));
        chk("single_core_in", core_in[N-1:0], N'(5));

        for (int v = 0; v < 8; v++) begin
            if (tv[v].rst) do_reset();
            apply(tv[v].mask, tv[v].base);
            for (int k = 0; k < tv[v].n; k++)
                push(tv[v].ord[k], 1'b0, tv[v].base + N'(tv[v].ord[k]) + N'(1));
            drain(1000);
        end

        resp_ready = 1'b0;
        apply(4'b0100, N'(100));
        push(2'd2, 1'b0, N'(103));
        for (int n = 0; n < 200 && !resp_valid; n++) step();
        apply(4'b0001, N'(110));
        push(2'd0, 1'b0, N'(111));
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", resp_valid, 1);
            chk("bp_state", resp_state[N-1:0], N'(103));
            chk("bp_busy", busy, 1);
            chk("bp_no_ready", req_ready, 0);
            step();
        end
        resp_ready = 1'b1;
        drain(200);

        hang = 1'b1;
        cr_cnt = 0;
        apply(4'b0010, N'(7));
        push(2'd1, 1'b1, N'(0));
        drain(300);
        chk("wd_delay", N'(cr_cyc - en_cyc), N'(TO));
        chk("wd_pulses", N'(cr_cnt), N'(1));
        hang = 1'b0;
        apply(4'b0100, N'(50));
        push(2'd2, 1'b0, N'(53));
        drain(200);

        apply(4'b0001, N'(60));
        repeat (22) step();
        chk("mid_busy", busy, 1);
        do_reset();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_jobs", jobs_done, 0);
        begin
            logic seen = 1'b0;
            for (int n = 0; n < 60; n++) begin
                seen = seen | resp_valid;
                step();
            end
            chk("post_rst_no_resp", seen, 0);
        end
        apply(4'b1001, N'(70));
        push(2'd0, 1'b0, N'(71));
        push(2'd3, 1'b0, N'(74));
        drain(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
